alu_operand_loader: RTL and testbench

ALU_OPERAND_LOADER -- requirements
Module: alu_operand_loader

---
 rtl/cpu_types_pkg.sv | 64 ++++++
 rtl/ALU_if.sv | 12 +
 rtl/key_debounce.sv | 51 +++++
 rtl/alu_operand_loader.sv | 114 +++++++++++
 tb/tb_alu_operand_loader.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: ALU operation encoding, operand-loader FSM states and
// the switch op-code constants used to select an ALU operation.
package cpu_types_pkg;

  typedef enum logic [3:0] {
    ALU_SLL  = 4'h0,
    ALU_SRL  = 4'h1,
    ALU_ADD  = 4'h2,
    ALU_SUB  = 4'h3,
    ALU_AND  = 4'h4,
    ALU_OR   = 4'h5,
    ALU_XOR  = 4'h6,
    ALU_NOR  = 4'h7,
    ALU_SLT  = 4'h8,
    ALU_SLTU = 4'h9
  } aluop_t;

  typedef enum logic [2:0] {
    ST_A_LO = 3'd0,
    ST_A_HI = 3'd1,
    ST_B_LO = 3'd2,
    ST_B_HI = 3'd3,
    ST_OP   = 3'd4,
    ST_DONE = 3'd5
  } loader_state_t;

  // Codes entered on SW[3:0] while the loader waits for the operation.
  localparam logic [3:0] SW_OP_SLL  = 4'd0;
  localparam logic [3:0] SW_OP_SRL  = 4'd1;
  localparam logic [3:0] SW_OP_ADD  = 4'd2;
  localparam logic [3:0] SW_OP_SUB  = 4'd3;
  localparam logic [3:0] SW_OP_AND  = 4'd4;
  localparam logic [3:0] SW_OP_OR   = 4'd5;
  localparam logic [3:0] SW_OP_XOR  = 4'd6;
  localparam logic [3:0] SW_OP_NOR  = 4'd7;
  localparam logic [3:0] SW_OP_SLT  = 4'd10;
  localparam logic [3:0] SW_OP_SLTU = 4'd11;

  function automatic logic sw_op_supported(input logic [3:0] code);
    logic ok;
    ok = code inside {SW_OP_SLL, SW_OP_SRL, SW_OP_ADD, SW_OP_SUB,
                      SW_OP_AND, SW_OP_OR, SW_OP_XOR, SW_OP_NOR,
                      SW_OP_SLT, SW_OP_SLTU};
    return ok;
  endfunction

  function automatic aluop_t sw_to_aluop(input logic [3:0] code);
    aluop_t op;
    case (code)
      SW_OP_SRL:  op = ALU_SRL;
      SW_OP_ADD:  op = ALU_ADD;
      SW_OP_SUB:  op = ALU_SUB;
      SW_OP_AND:  op = ALU_AND;
      SW_OP_OR:   op = ALU_OR;
      SW_OP_XOR:  op = ALU_XOR;
      SW_OP_NOR:  op = ALU_NOR;
      SW_OP_SLT:  op = ALU_SLT;
      SW_OP_SLTU: op = ALU_SLTU;
      default:    op = ALU_SLL;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/ALU_if.sv
// Operand/operation bus between the operand loader (master) and the ALU (slave).
interface ALU_if;
  import cpu_types_pkg::*;

  logic [31:0] Port_A;
  logic [31:0] Port_B;
  aluop_t      ALUOP;

  modport master (output Port_A, output Port_B, output ALUOP);
  modport slave  (input  Port_A, input  Port_B, input  ALUOP);

endinterface

// File: rtl/key_debounce.sv
// One push-button: 2-flop synchronizer, level debouncer and a one-cycle
// press pulse on each debounced high-to-low transition.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic press
);

  // Counter only has to reach DEBOUNCE_CYCLES-1; DEBOUNCE_CYCLES is at least 2.
  localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q, sync_d;
  logic             level_q, level_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_q, press_d;

  always_comb begin
    sync_d  = {sync_q[0], key_n};
    level_d = level_q;
    cnt_d   = '0;
    if (sync_q[1] != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
    press_d = level_q & ~level_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= 2'b11;
      level_q <= 1'b1;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/alu_operand_loader.sv
// Loads two 32-bit ALU operands and an operation from 16 switches, one
// half-word per debounced commit press; a clear press restarts the sequence.
module alu_operand_loader
  import cpu_types_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [3:0]  KEY,
  input  logic [15:0] SW,
  ALU_if.master       alu_bus,
  output logic        valid,
  output logic [2:0]  stage,
  output logic        op_err
);

  logic [3:0] press;
  logic       commit_press;
  logic       clear_press;
  logic       unused_press;

  for (genvar i = 0; i < 4; i++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key (
      .clk  (CLK),
      .rst  (RST),
      .key_n(KEY[i]),
      .press(press[i])
    );
  end

  assign commit_press = press[0];
  assign clear_press  = press[1];
  // KEY[3:2] are reserved buttons with no function yet.
  assign unused_press = ^press[3:2];

  loader_state_t state_q, state_d;
  logic [31:0]   port_a_q, port_a_d;
  logic [31:0]   port_b_q, port_b_d;
  aluop_t        aluop_q, aluop_d;
  logic          op_err_q, op_err_d;

  always_comb begin
    state_d  = state_q;
    port_a_d = port_a_q;
    port_b_d = port_b_q;
    aluop_d  = aluop_q;
    op_err_d = 1'b0;
    // Clear has priority so a simultaneous commit never captures anything.
    if (clear_press) begin
      state_d  = ST_A_LO;
      port_a_d = '0;
      port_b_d = '0;
      aluop_d  = ALU_SLL;
    end else begin
      case (state_q)
        ST_A_LO: if (commit_press) begin
          port_a_d[15:0] = SW;
          state_d        = ST_A_HI;
        end
        ST_A_HI: if (commit_press) begin
          port_a_d[31:16] = SW;
          state_d         = ST_B_LO;
        end
        ST_B_LO: if (commit_press) begin
          port_b_d[15:0] = SW;
          state_d        = ST_B_HI;
        end
        ST_B_HI: if (commit_press) begin
          port_b_d[31:16] = SW;
          state_d         = ST_OP;
        end
        ST_OP: if (commit_press) begin
          if (sw_op_supported(SW[3:0])) begin
            aluop_d = sw_to_aluop(SW[3:0]);
            state_d = ST_DONE;
          end else begin
            op_err_d = 1'b1;
          end
        end
        ST_DONE: if (commit_press) begin
          state_d = ST_A_LO;
        end
        default: state_d = ST_A_LO;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= ST_A_LO;
      port_a_q <= '0;
      port_b_q <= '0;
      aluop_q  <= ALU_SLL;
      op_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      port_a_q <= port_a_d;
      port_b_q <= port_b_d;
      aluop_q  <= aluop_d;
      op_err_q <= op_err_d;
    end
  end

  assign alu_bus.Port_A = port_a_q;
  assign alu_bus.Port_B = port_b_q;
  assign alu_bus.ALUOP  = aluop_q;
  assign valid          = (state_q == ST_DONE);
  assign stage          = state_q;
  assign op_err         = op_err_q;

endmodule

// File: tb/tb_alu_operand_loader.sv
// Directed bench for alu_operand_loader with a short debounce window:
// a vector table of key presses plus hand-written multi-cycle sequences.
module tb_alu_operand_loader;
  import cpu_types_pkg::*;

  localparam int N = 4;

  logic        CLK = 1'b0;
  logic        RST;
  logic [3:0]  KEY;
  logic [15:0] SW;
  logic        valid;
  logic [2:0]  stage;
  logic        op_err;

  ALU_if alu_bus ();

  alu_operand_loader #(
    .DEBOUNCE_CYCLES(N)
  ) dut (
    .CLK    (CLK),
    .RST    (RST),
    .KEY    (KEY),
    .SW     (SW),
    .alu_bus(alu_bus),
    .valid  (valid),
    .stage  (stage),
    .op_err (op_err)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [3:0]  key_low;
    logic [15:0] sw;
    logic [2:0]  stage;
    logic [31:0] a;
    logic [31:0] b;
    aluop_t      op;
    logic        valid;
    logic [3:0]  err;
  } vec_t;

  typedef struct packed {
    logic   ok;
    aluop_t op;
  } op_exp_t;

  vec_t    vecs [19];
  op_exp_t op_tbl [16];
  int      tests_run = 0;
  int      tests_failed = 0;
  int      err_cycles = 0;
  aluop_t  prev_op;

  task automatic check_output(input string what, input logic [31:0] actual,
                              input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h", what, actual, expected);
    end
  endtask

  task automatic check_state(input string tag, input logic [2:0] exp_stage,
                             input logic [31:0] exp_a, input logic [31:0] exp_b,
                             input aluop_t exp_op, input logic exp_valid);
    check_output({tag, " stage"}, 32'(stage), 32'(exp_stage));
    check_output({tag, " Port_A"}, alu_bus.Port_A, exp_a);
    check_output({tag, " Port_B"}, alu_bus.Port_B, exp_b);
    check_output({tag, " ALUOP"}, 32'(alu_bus.ALUOP), 32'(exp_op));
    check_output({tag, " valid"}, 32'(valid), 32'(exp_valid));
  endtask

  // Hold the masked keys low long enough to debounce, then release them fully.
  task automatic apply_stimulus(input logic [3:0] low_mask, input logic [15:0] sw_val);
    err_cycles = 0;
    SW  = sw_val;
    KEY = ~low_mask;
    for (int c = 0; c < N + 6; c++) begin
      @(negedge CLK);
      if (op_err) err_cycles++;
    end
    KEY = 4'hF;
    for (int c = 0; c < N + 6; c++) begin
      @(negedge CLK);
      if (op_err) err_cycles++;
    end
  endtask

  task automatic goto_op();
    for (int k = 1; k <= 4; k++) apply_stimulus(4'b0001, 16'(16'h0101 * k));
  endtask

  initial begin
    vecs[0]  = '{4'b0001, 16'h1234, 3'd1, 32'h0000_1234, 32'h0000_0000, ALU_SLL,  1'b0, 4'd0};
    vecs[1]  = '{4'b1000, 16'hFFFF, 3'd1, 32'h0000_1234, 32'h0000_0000, ALU_SLL,  1'b0, 4'd0};
    vecs[2]  = '{4'b0001, 16'h5678, 3'd2, 32'h5678_1234, 32'h0000_0000, ALU_SLL,  1'b0, 4'd0};
    vecs[3]  = '{4'b0001, 16'h9ABC, 3'd3, 32'h5678_1234, 32'h0000_9ABC, ALU_SLL,  1'b0, 4'd0};
    vecs[4]  = '{4'b0001, 16'hDEF0, 3'd4, 32'h5678_1234, 32'hDEF0_9ABC, ALU_SLL,  1'b0, 4'd0};
    vecs[5]  = '{4'b0001, 16'h0002, 3'd5, 32'h5678_1234, 32'hDEF0_9ABC, ALU_ADD,  1'b1, 4'd0};
    vecs[6]  = '{4'b0100, 16'h0005, 3'd5, 32'h5678_1234, 32'hDEF0_9ABC, ALU_ADD,  1'b1, 4'd0};
    vecs[7]  = '{4'b0001, 16'h0007, 3'd0, 32'h5678_1234, 32'hDEF0_9ABC, ALU_ADD,  1'b0, 4'd0};
    vecs[8]  = '{4'b0001, 16'hAAAA, 3'd1, 32'h5678_AAAA, 32'hDEF0_9ABC, ALU_ADD,  1'b0, 4'd0};
    vecs[9]  = '{4'b0001, 16'h1111, 3'd2, 32'h1111_AAAA, 32'hDEF0_9ABC, ALU_ADD,  1'b0, 4'd0};
    vecs[10] = '{4'b0001, 16'h2222, 3'd3, 32'h1111_AAAA, 32'hDEF0_2222, ALU_ADD,  1'b0, 4'd0};
    vecs[11] = '{4'b0001, 16'h3333, 3'd4, 32'h1111_AAAA, 32'h3333_2222, ALU_ADD,  1'b0, 4'd0};
    vecs[12] = '{4'b0001, 16'h0008, 3'd4, 32'h1111_AAAA, 32'h3333_2222, ALU_ADD,  1'b0, 4'd1};
    vecs[13] = '{4'b0001, 16'h00FB, 3'd5, 32'h1111_AAAA, 32'h3333_2222, ALU_SLTU, 1'b1, 4'd0};
    vecs[14] = '{4'b0001, 16'h0000, 3'd0, 32'h1111_AAAA, 32'h3333_2222, ALU_SLTU, 1'b0, 4'd0};
    vecs[15] = '{4'b0001, 16'hFFFF, 3'd1, 32'h1111_FFFF, 32'h3333_2222, ALU_SLTU, 1'b0, 4'd0};
    vecs[16] = '{4'b0001, 16'hFFFF, 3'd2, 32'hFFFF_FFFF, 32'h3333_2222, ALU_SLTU, 1'b0, 4'd0};
    vecs[17] = '{4'b0001, 16'h0001, 3'd3, 32'hFFFF_FFFF, 32'h3333_0001, ALU_SLTU, 1'b0, 4'd0};
    vecs[18] = '{4'b0010, 16'h1234, 3'd0, 32'h0000_0000, 32'h0000_0000, ALU_SLL,  1'b0, 4'd0};

    op_tbl[0]  = '{1'b1, ALU_SLL};
    op_tbl[1]  = '{1'b1, ALU_SRL};
    op_tbl[2]  = '{1'b1, ALU_ADD};
    op_tbl[3]  = '{1'b1, ALU_SUB};
    op_tbl[4]  = '{1'b1, ALU_AND};
    op_tbl[5]  = '{1'b1, ALU_OR};
    op_tbl[6]  = '{1'b1, ALU_XOR};
    op_tbl[7]  = '{1'b1, ALU_NOR};
    op_tbl[8]  = '{1'b0, ALU_SLL};
    op_tbl[9]  = '{1'b0, ALU_SLL};
    op_tbl[10] = '{1'b1, ALU_SLT};
    op_tbl[11] = '{1'b1, ALU_SLTU};
    op_tbl[12] = '{1'b0, ALU_SLL};
    op_tbl[13] = '{1'b0, ALU_SLL};
    op_tbl[14] = '{1'b0, ALU_SLL};
    op_tbl[15] = '{1'b0, ALU_SLL};

    RST = 1'b1;
    KEY = 4'hF;
    SW  = 16'h0000;
    repeat (3) @(negedge CLK);
    check_state("reset", 3'd0, 32'h0, 32'h0, ALU_SLL, 1'b0);
    check_output("reset op_err", 32'(op_err), 32'h0);
    RST = 1'b0;
    repeat (2) @(negedge CLK);

    for (int i = 0; i < 19; i++) begin
      apply_stimulus(vecs[i].key_low, vecs[i].sw);
      check_state($sformatf("vec%0d", i), vecs[i].stage, vecs[i].a, vecs[i].b,
                  vecs[i].op, vecs[i].valid);
      check_output($sformatf("vec%0d op_err cycles", i), 32'(err_cycles), 32'(vecs[i].err));
    end

    prev_op = ALU_SLL;
    goto_op();
    for (int code = 0; code < 16; code++) begin
      apply_stimulus(4'b0001, {12'hA5C, 4'(code)});
      if (op_tbl[code].ok) begin
        check_output($sformatf("op%0d stage", code), 32'(stage), 32'd5);
        check_output($sformatf("op%0d ALUOP", code), 32'(alu_bus.ALUOP), 32'(op_tbl[code].op));
        check_output($sformatf("op%0d valid", code), 32'(valid), 32'd1);
        prev_op = op_tbl[code].op;
        apply_stimulus(4'b0001, 16'h0000);
        goto_op();
      end else begin
        check_output($sformatf("op%0d stage", code), 32'(stage), 32'd4);
        check_output($sformatf("op%0d ALUOP", code), 32'(alu_bus.ALUOP), 32'(prev_op));
        check_output($sformatf("op%0d op_err cycles", code), 32'(err_cycles), 32'd1);
        check_output($sformatf("op%0d valid", code), 32'(valid), 32'd0);
      end
    end

    // Commit and clear pressed together in A_HI: clear wins, SW not captured.
    apply_stimulus(4'b0010, 16'h0000);
    apply_stimulus(4'b0001, 16'h1357);
    check_output("simul pre stage", 32'(stage), 32'd1);
    apply_stimulus(4'b0011, 16'hBEEF);
    check_state("simul", 3'd0, 32'h0, 32'h0, ALU_SLL, 1'b0);

    // Bouncing commit: 3 low, 1 high, then steady low; one press at N+3 edges.
    SW  = 16'h4321;
    KEY = 4'b1110;
    repeat (3) @(negedge CLK);
    KEY = 4'b1111;
    @(negedge CLK);
    KEY = 4'b1110;
    for (int k = 1; k <= 10; k++) begin
      @(negedge CLK);
      check_output($sformatf("bounce edge%0d stage", k), 32'(stage),
                   (k >= N + 3) ? 32'd1 : 32'd0);
    end
    KEY = 4'hF;
    repeat (2 * N + 6) @(negedge CLK);
    check_state("bounce end", 3'd1, 32'h0000_4321, 32'h0, ALU_SLL, 1'b0);

    apply_stimulus(4'b0001, 16'h8765);
    apply_stimulus(4'b0001, 16'h0F0F);
    apply_stimulus(4'b0001, 16'hF0F0);
    apply_stimulus(4'b0001, 16'h0003);
    check_state("pre-reset done", 3'd5, 32'h8765_4321, 32'hF0F0_0F0F, ALU_SUB, 1'b1);

    // Reset while in DONE with commit held low mid-debounce.
    KEY = 4'b1110;
    repeat (2) @(negedge CLK);
    check_output("hold in done stage", 32'(stage), 32'd5);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    check_state("reset in done", 3'd0, 32'h0, 32'h0, ALU_SLL, 1'b0);
    check_output("reset in done op_err", 32'(op_err), 32'h0);
    repeat (2) @(negedge CLK);
    KEY = 4'hF;
    repeat (3 * N + 6) @(negedge CLK);
    check_state("after reset no press", 3'd0, 32'h0, 32'h0, ALU_SLL, 1'b0);
    apply_stimulus(4'b0001, 16'h00C3);
    check_state("after reset press", 3'd1, 32'h0000_00C3, 32'h0, ALU_SLL, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
